// File: rtl/fifo_ctrl.sv
// Purpose: pointer/status controller for a 16-entry byte FIFO (FWFT read side); optional macro FIFO_CTRL_STICKY_ERR_EN makes overflow/underflow sticky until rst.
// Latency: pointers advance one cycle after an accepted op; status is combinational from registered pointers; error flags lag by one cycle.
// Backpressure: wr is dropped while full and rd is dropped while empty; dropped ops never move pointers.
module fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    output logic              fifo_we,
    output logic              fifo_rd,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rptr,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_threshold,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    // Threshold narrowed to pointer width; 2**ADDR_W still fits thanks to the wrap bit.
    localparam logic [ADDR_W:0] THRESH_V = THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    // Status decode: equal pointers mean empty, equal index with differing wrap bit means full.
    always_comb begin
        fifo_empty     = (wptr_q == rptr_q);
        fifo_full      = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                         (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
        fifo_count     = wptr_q - rptr_q;
        fifo_threshold = (fifo_count >= THRESH_V);
        fifo_we        = wr & ~fifo_full;
        fifo_rd        = rd & ~fifo_empty;
    end

    // Next-state: pointers step on accepted ops and wrap naturally at the pointer width.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (fifo_we) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (fifo_rd) begin
            rptr_d = rptr_q + PTR_ONE;
        end
`ifdef FIFO_CTRL_STICKY_ERR_EN
        // Once raised, a flag holds until reset.
        ovf_d = ovf_q | (wr & fifo_full);
        udf_d = udf_q | (rd & fifo_empty);
`else
        // One pulse per offending cycle.
        ovf_d = wr & fifo_full;
        udf_d = rd & fifo_empty;
`endif
    end

    // State registers; reset aborts any in-flight update immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign wptr           = wptr_q;
    assign rptr           = rptr_q;
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and status controller for the 16-entry byte FIFO.
- Sits directly upstream of the FIFO memory array and drives its write enable and its 5-bit write/read pointers.
- Accepts raw wr/rd requests from producer and consumer, gates them against full/empty, and advances the pointers.
- Produces full, empty, threshold, occupancy and overflow/underflow status; read data is taken combinationally from the array at rptr (first-word-fall-through).

Parameters:
- ADDR_W, 4, array address width; depth = 2**ADDR_W = 16; pointers are ADDR_W+1 bits, with the MSB as the wrap bit.
- THRESH, 12, occupancy level at or above which fifo_threshold asserts; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- wr  input  1  producer write request (data presented to the array in the same cycle).
- rd  input  1  consumer read request; acknowledges the word currently at rptr.
- fifo_we  output  1  gated write enable to the memory array.
- fifo_rd  output  1  gated read strobe (rd accepted this cycle).
- wptr  output  ADDR_W+1  write pointer to the memory array.
- rptr  output  ADDR_W+1  read pointer to the memory array.
- fifo_full  output  1  FIFO holds 2**ADDR_W words.
- fifo_empty  output  1  FIFO holds 0 words.
- fifo_threshold  output  1  occupancy >= THRESH.
- fifo_count  output  ADDR_W+1  current occupancy, 0..16.
- fifo_overflow  output  1  write attempted while full.
- fifo_underflow  output  1  read attempted while empty.

Behaviour:
- Reset (async assert, sync release by clk domain):
  - wptr = rptr = 0, fifo_count = 0.
  - fifo_empty = 1; fifo_full, fifo_threshold, fifo_overflow and fifo_underflow = 0.
  - Array contents are untouched but logically discarded.
  - Reset mid-transfer aborts immediately; no partial pointer update.
- Gating (combinational from current-cycle state):
  - fifo_we = wr & ~fifo_full.
  - fifo_rd = rd & ~fifo_empty.
- Pointers:
  - wptr <= wptr + 1 on posedge when fifo_we; rptr <= rptr + 1 when fifo_rd.
  - Both wrap modulo 2**(ADDR_W+1); 15 -> 16 toggles the MSB, 31 -> 0.
- Status (combinational from registered pointers; no extra latency):
  - fifo_empty = (wptr == rptr).
  - fifo_full = (wptr[ADDR_W] != rptr[ADDR_W]) & (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]).
  - fifo_count = wptr - rptr, modulo 2**(ADDR_W+1).
  - fifo_threshold = (fifo_count >= THRESH).
- Latency:
  - A write accepted in cycle N is readable (fifo_empty low, data at rptr) from cycle N+1.
  - A read in cycle N exposes the next word at cycle N+1.
- Simultaneous wr & rd:
  - Neither full nor empty: both pointers advance; count unchanged.
  - Full: read accepted, write dropped; next cycle count = 15, full = 0.
  - Empty: write accepted, read dropped; next cycle count = 1, empty = 0.
- Error flags (registered, one-cycle latency):
  - fifo_overflow <= wr & fifo_full, regardless of rd.
  - fifo_underflow <= rd & fifo_empty, regardless of wr.
  - Without the optional feature, each flag is a single-cycle pulse per offending cycle.
- Dropped operations never alter pointers or count.

Optional Feature:
- Macro: FIFO_CTRL_STICKY_ERR_EN.
- Defined: fifo_overflow and fifo_underflow are sticky. Once set, they hold 1 until rst and ignore further wr/rd activity.
- Undefined: the flags pulse exactly as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst mid-burst with count = 7 -> wptr = rptr = 0, count = 0, empty = 1, all other flags 0, asynchronously (before the next clk edge).
- Fill: 16 consecutive wr from empty.
  - threshold rises the cycle count reaches 12.
  - full = 1 after the 16th write, wptr = 16, rptr = 0.
  - A 17th wr -> fifo_we = 0, wptr stays 16, overflow = 1 on the next cycle.
- Drain: 16 rd from full -> data returned in write order (e.g. 0x00..0x0F), empty = 1 with rptr = 16. A further rd -> fifo_rd = 0, underflow = 1 on the next cycle.
- Wrap: 40 cycles of wr & rd with count held at 5 -> pointers cross 31 -> 0, count stays 5, full and empty never assert, data order preserved.
- Simultaneous at boundaries:
  - wr & rd when full -> count 15, full = 0, no overflow pulse suppression (overflow = 1).
  - wr & rd when empty -> count 1, underflow = 1.
- Sticky build (FIFO_CTRL_STICKY_ERR_EN): trigger an overflow, then 10 idle cycles -> overflow remains 1 until rst; without the macro it is 1 for exactly one cycle.
